lif_neuron: RTL and testbench

Parametrised leaky integrate-and-fire neuron. It generalises the single-input integrate-and-fire neuron to NUM_SYN weighted synapses, with a runtime-writable weight table, shift-based leak, saturating potential, selectable post-spike reset mode and a refractory period. Neurons are instantiated in arrays inside a layer. A layer controller broadcasts a timestep strobe and programs weights.

---
 rtl/lif_neuron.sv | 118 +++++++++++
 tb/tb_lif_neuron.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: NUM_SYN weighted synapses, shift leak,
// saturating non-negative potential, selectable post-spike reset, refractory.
module lif_neuron #(
  parameter int NUM_SYN       = 4,
  parameter int WEIGHT_W      = 8,
  parameter int POT_W         = 16,
  parameter int THRESHOLD     = 10,
  parameter int LEAK_SHIFT    = 3,
  parameter int REFRACT_TICKS = 2,
  parameter int RESET_MODE    = 0,
  parameter int INIT_WEIGHT   = 1,
  localparam int AW           = (NUM_SYN > 1) ? $clog2(NUM_SYN) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                tick_i,
  input  logic [NUM_SYN-1:0]  axon_i,
  input  logic                wr_en_i,
  input  logic [AW-1:0]       wr_addr_i,
  input  logic [WEIGHT_W-1:0] wr_data_i,
  output logic                spike_o,
  output logic [POT_W-1:0]    potential_o,
  output logic                refract_o
);
  localparam int SUM_W = WEIGHT_W + $clog2(NUM_SYN) + 1;
  localparam int EXT_W = ((POT_W > SUM_W) ? POT_W : SUM_W) + 2;
  localparam int CNT_W = (REFRACT_TICKS > 0) ? $clog2(REFRACT_TICKS + 1) : 1;
  localparam logic [POT_W-1:0]           POT_MAX  = {1'b0, {(POT_W-1){1'b1}}};
  localparam logic [POT_W-1:0]           THR      = POT_W'(THRESHOLD);
  localparam logic signed [WEIGHT_W-1:0] W_INIT   = WEIGHT_W'(INIT_WEIGHT);
  localparam logic [CNT_W-1:0]           CNT_INIT = CNT_W'(REFRACT_TICKS);

  typedef enum logic {INTEGRATE, REFRACTORY} state_t;

  logic signed [WEIGHT_W-1:0] weight [NUM_SYN];
  state_t                     state, state_d;
  logic [POT_W-1:0]           pot, pot_d, leaked, clamped;
  logic [CNT_W-1:0]           cnt, cnt_d;
  logic                       spike, spike_d;
  logic signed [SUM_W-1:0]    sum;
  logic signed [EXT_W-1:0]    n_raw;

  // Addresses at or above NUM_SYN match no entry, so those writes drop out.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_SYN; k++) weight[k] <= W_INIT;
    end else begin
      for (int k = 0; k < NUM_SYN; k++)
        if (wr_en_i && wr_addr_i == AW'(k)) weight[k] <= wr_data_i;
    end
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < NUM_SYN; k++)
      if (axon_i[k]) sum = sum + {{(SUM_W-WEIGHT_W){weight[k][WEIGHT_W-1]}}, weight[k]};
  end

  assign leaked = (LEAK_SHIFT == 0) ? pot : pot - (pot >> LEAK_SHIFT);
  assign n_raw  = $signed({{(EXT_W-POT_W){1'b0}}, leaked})
                + $signed({{(EXT_W-SUM_W){sum[SUM_W-1]}}, sum});

  always_comb begin
    if (n_raw[EXT_W-1])
      clamped = '0;
    else if (n_raw > $signed({{(EXT_W-POT_W){1'b0}}, POT_MAX}))
      clamped = POT_MAX;
    else
      clamped = n_raw[POT_W-1:0];
  end

  always_comb begin
    state_d = state;
    pot_d   = pot;
    cnt_d   = cnt;
    spike_d = 1'b0;
    if (tick_i) begin
      case (state)
        INTEGRATE: begin
          if (clamped >= THR) begin
            spike_d = 1'b1;
            pot_d   = (RESET_MODE == 1) ? clamped - THR : '0;
            if (REFRACT_TICKS > 0) begin
              cnt_d   = CNT_INIT;
              state_d = REFRACTORY;
            end
          end else begin
            pot_d = clamped;
          end
        end
        REFRACTORY: begin
          // Potential frozen; leave once the count has run down to zero.
          cnt_d = cnt - 1'b1;
          if (cnt <= CNT_W'(1)) state_d = INTEGRATE;
        end
        default: state_d = INTEGRATE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= INTEGRATE;
      pot   <= '0;
      cnt   <= '0;
      spike <= 1'b0;
    end else begin
      state <= state_d;
      pot   <= pot_d;
      cnt   <= cnt_d;
      spike <= spike_d;
    end
  end

  assign spike_o     = spike;
  assign potential_o = pot;
  assign refract_o   = (state == REFRACTORY);
endmodule

// File: tb/tb_lif_neuron.sv
// Bench for lif_neuron: five configurations share one stimulus bus; directed
// vectors with hand-derived values, then random stimulus against a model.
module tb_lif_neuron;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, tick, we;
  logic [3:0] axon;
  logic [1:0] addr;
  logic [7:0] data;
  logic [4:0] spk, rf;
  logic [15:0] p0, p1, p3, p4;
  logic [7:0]  p2;

  int checks = 0;
  int failures = 0;

  lif_neuron u0 (.clk_i(clk), .rst_i(rst), .tick_i(tick), .axon_i(axon), .wr_en_i(we),
    .wr_addr_i(addr), .wr_data_i(data), .spike_o(spk[0]), .potential_o(p0), .refract_o(rf[0]));
  lif_neuron #(.THRESHOLD(1000)) u1 (.clk_i(clk), .rst_i(rst), .tick_i(tick), .axon_i(axon),
    .wr_en_i(we), .wr_addr_i(addr), .wr_data_i(data), .spike_o(spk[1]), .potential_o(p1),
    .refract_o(rf[1]));
  lif_neuron #(.POT_W(8), .THRESHOLD(127)) u2 (.clk_i(clk), .rst_i(rst), .tick_i(tick),
    .axon_i(axon), .wr_en_i(we), .wr_addr_i(addr), .wr_data_i(data), .spike_o(spk[2]),
    .potential_o(p2), .refract_o(rf[2]));
  lif_neuron #(.RESET_MODE(1)) u3 (.clk_i(clk), .rst_i(rst), .tick_i(tick), .axon_i(axon),
    .wr_en_i(we), .wr_addr_i(addr), .wr_data_i(data), .spike_o(spk[3]), .potential_o(p3),
    .refract_o(rf[3]));
  lif_neuron #(.NUM_SYN(3), .THRESHOLD(20), .LEAK_SHIFT(0), .REFRACT_TICKS(0)) u4 (
    .clk_i(clk), .rst_i(rst), .tick_i(tick), .axon_i(axon[2:0]), .wr_en_i(we),
    .wr_addr_i(addr), .wr_data_i(data), .spike_o(spk[4]), .potential_o(p4), .refract_o(rf[4]));

  // Per-instance configuration, mirrored from the parameter overrides above.
  int c_ns [5] = '{4, 4, 4, 4, 3};
  int c_pw [5] = '{16, 16, 8, 16, 16};
  int c_thr[5] = '{10, 1000, 127, 10, 20};
  int c_ls [5] = '{3, 3, 3, 3, 0};
  int c_rt [5] = '{2, 2, 2, 2, 0};
  int c_rm [5] = '{0, 0, 0, 1, 0};

  int m_pot[5], m_cnt[5], m_spk[5];
  int m_w[5][4];

  function automatic logic [31:0] get_pot(input int d);
    case (d)
      0: return {16'h0, p0};
      1: return {16'h0, p1};
      2: return {24'h0, p2};
      3: return {16'h0, p3};
      default: return {16'h0, p4};
    endcase
  endfunction

  // Reference model: refractory is simply "ticks still to skip > 0".
  task automatic model_step();
    int s, n, top;
    for (int d = 0; d < 5; d++) begin
      if (rst) begin
        m_pot[d] = 0; m_cnt[d] = 0; m_spk[d] = 0;
        for (int k = 0; k < 4; k++) m_w[d][k] = 1;
      end else begin
        m_spk[d] = 0;
        if (tick) begin
          if (m_cnt[d] > 0) m_cnt[d]--;
          else begin
            s = 0;
            for (int k = 0; k < c_ns[d]; k++) if (axon[k]) s += m_w[d][k];
            n = m_pot[d] - ((c_ls[d] > 0) ? (m_pot[d] >> c_ls[d]) : 0) + s;
            top = (1 << (c_pw[d] - 1)) - 1;
            if (n < 0) n = 0;
            if (n > top) n = top;
            if (n >= c_thr[d]) begin
              m_spk[d] = 1;
              m_pot[d] = (c_rm[d] == 1) ? n - c_thr[d] : 0;
              m_cnt[d] = c_rt[d];
            end else m_pot[d] = n;
          end
        end
        if (we && int'(addr) < c_ns[d]) m_w[d][addr] = int'($signed(data));
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  typedef struct {
    bit rst, tick; bit [3:0] axon; bit we; bit [1:0] addr; bit [7:0] data;
    int d; int pot; bit spk, rf;
  } vec_t;
  vec_t vt[$];

  function automatic void v(input bit r, input bit t, input bit [3:0] ax, input bit w,
                            input bit [1:0] a, input int dt, input int d, input int p,
                            input bit s, input bit f);
    vec_t e;
    e.rst = r; e.tick = t; e.axon = ax; e.we = w; e.addr = a; e.data = 8'(dt);
    e.d = d; e.pot = p; e.spk = s; e.rf = f;
    vt.push_back(e);
  endfunction

  initial begin
    rst = 1'b1; tick = 1'b0; axon = '0; we = 1'b0; addr = '0; data = '0;

    // Defaults: fire at 12, refractory for two ticks, reset mid-refractory.
    v(1,0,4'h0,0,0,0,   0,0,0,0);
    v(0,0,4'h0,1,0,3,   0,0,0,0);
    v(0,0,4'h0,1,1,3,   0,0,0,0);
    v(0,1,4'h3,0,0,0,   0,6,0,0);
    v(0,1,4'h3,0,0,0,   0,0,1,1);
    v(0,1,4'h3,0,0,0,   0,0,0,1);
    v(0,1,4'h3,0,0,0,   0,0,0,0);
    v(0,1,4'h3,0,0,0,   0,6,0,0);
    v(0,0,4'h3,0,0,0,   0,6,0,0);
    v(0,1,4'h3,0,0,0,   0,0,1,1);
    v(1,1,4'hF,1,0,77,  0,0,0,0);
    v(0,1,4'hF,0,0,0,   0,4,0,0);
    // Leak decay with a high threshold.
    v(1,0,4'h0,0,0,0,   1,0,0,0);
    v(0,0,4'h0,1,0,100, 1,0,0,0);
    v(0,1,4'h1,0,0,0,   1,100,0,0);
    v(0,1,4'h0,0,0,0,   1,88,0,0);
    v(0,1,4'h0,0,0,0,   1,77,0,0);
    v(0,1,4'h0,0,0,0,   1,68,0,0);
    v(0,1,4'h0,0,0,0,   1,60,0,0);
    // Negative sum clamps at 0.
    v(1,0,4'h0,0,0,0,   0,0,0,0);
    v(0,0,4'h0,1,2,-5,  0,0,0,0);
    v(0,1,4'h4,0,0,0,   0,0,0,0);
    // 8-bit potential saturates at 127 and fires.
    v(1,0,4'h0,0,0,0,   2,0,0,0);
    v(0,0,4'h0,1,0,100, 2,0,0,0);
    v(0,0,4'h0,1,1,100, 2,0,0,0);
    v(0,0,4'h0,1,2,100, 2,0,0,0);
    v(0,0,4'h0,1,3,100, 2,0,0,0);
    v(0,1,4'hF,0,0,0,   2,0,1,1);
    // Subtractive reset, held potential in refractory, write racing a tick.
    v(1,0,4'h0,0,0,0,   3,0,0,0);
    v(0,0,4'h0,1,0,3,   3,0,0,0);
    v(0,0,4'h0,1,1,3,   3,0,0,0);
    v(0,1,4'h3,0,0,0,   3,6,0,0);
    v(0,1,4'h3,0,0,0,   3,2,1,1);
    v(0,1,4'h3,0,0,0,   3,2,0,1);
    v(0,1,4'h3,0,0,0,   3,2,0,0);
    v(0,1,4'h3,1,0,50,  3,8,0,0);
    v(0,1,4'h3,0,0,0,   3,50,1,1);
    // Three synapses: out-of-range write ignored, no leak, back-to-back spikes.
    v(1,0,4'h0,0,0,0,   4,0,0,0);
    v(0,0,4'h0,1,3,50,  4,0,0,0);
    v(0,1,4'h7,0,0,0,   4,3,0,0);
    v(0,0,4'h0,1,1,20,  4,3,0,0);
    v(0,1,4'h2,0,0,0,   4,0,1,0);
    v(0,1,4'h2,0,0,0,   4,0,1,0);
    v(0,1,4'h0,0,0,0,   4,0,0,0);

    foreach (vt[i]) begin
      rst = vt[i].rst; tick = vt[i].tick; axon = vt[i].axon;
      we = vt[i].we; addr = vt[i].addr; data = vt[i].data;
      step();
      chk($sformatf("vec%0d_pot", i), get_pot(vt[i].d), 32'(vt[i].pot));
      chk($sformatf("vec%0d_spike", i), 32'(spk[vt[i].d]), 32'(vt[i].spk));
      chk($sformatf("vec%0d_refract", i), 32'(rf[vt[i].d]), 32'(vt[i].rf));
    end

    rst = 1'b1; tick = 1'b0; we = 1'b0;
    step();
    for (int c = 0; c < 1500; c++) begin
      rst  = ($urandom_range(0, 63) == 0);
      tick = ($urandom_range(0, 3) != 0);
      axon = 4'($urandom);
      we   = ($urandom_range(0, 3) == 0);
      addr = 2'($urandom);
      data = 8'($urandom_range(0, 60) - 20);
      step();
      for (int d = 0; d < 5; d++) begin
        chk($sformatf("rnd%0d_u%0d_pot", c, d), get_pot(d), 32'(m_pot[d]));
        chk($sformatf("rnd%0d_u%0d_spike", c, d), 32'(spk[d]), 32'(m_spk[d]));
        chk($sformatf("rnd%0d_u%0d_refract", c, d), 32'(rf[d]), 32'(m_cnt[d] > 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
